// File: rtl/exec_unit.sv
// 6502 group-01 execute/writeback stage: updates A and {N,V,Z,C}, issues the STA write cycle.
// Latency: DONE 2 cycles after accept (binary ops), 3 for decimal ADC/SBC and STA; no acceptance while BUSY.
module exec_unit #(
  parameter logic [7:0] A_INIT     = 8'h00,
  parameter bit         DECIMAL_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_op_valid,
  input  logic [2:0]  i_opcode,
  input  logic [7:0]  i_operand,
  input  logic [15:0] i_ea,
  input  logic        i_d,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_reg_a,
  output logic [3:0]  o_flags,
  output logic        o_wr_en,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DEC_ADJ, S_STORE} state_t;

  localparam logic [2:0] OP_ORA = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_EOR = 3'b010;
  localparam logic [2:0] OP_ADC = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_SBC = 3'b111;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [7:0]  r_m;
  logic [15:0] r_ea;
  logic        r_d;
  logic [7:0]  r_a;
  logic [3:0]  r_flags;
  logic        r_done;
  logic        r_wr_en;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  // Binary intermediate held across the BCD-adjust cycle
  logic [8:0]  r_sum9;
  logic        r_hc;
  logic        r_v;

  logic        w_dec;
  logic [7:0]  w_m_eff;
  logic        w_cin;
  logic [8:0]  w_sum9;
  logic        w_v;
  logic        w_hc;
  logic [7:0]  w_res;
  logic        w_wr_a;
  logic [3:0]  w_flags;
  logic        w_lo_fix;
  logic        w_hi_fix;
  logic [8:0]  w_adj1;
  logic [7:0]  w_dadj;
  logic        w_dc;

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_reg_a   = r_a;
  assign o_flags   = r_flags;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

  assign w_dec = DECIMAL_EN && r_d && ((r_op == OP_ADC) || (r_op == OP_SBC));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_op_valid) w_next = S_EXEC;
      S_EXEC: begin
        if (r_op == OP_STA) w_next = S_STORE;
        else if (w_dec)     w_next = S_DEC_ADJ;
        else                w_next = S_IDLE;
      end
      S_DEC_ADJ: w_next = S_IDLE;
      S_STORE:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Shared adder: SBC and CMP add ~M; CMP always forces carry-in so it is a plain A-M
  always_comb begin
    w_m_eff = ((r_op == OP_SBC) || (r_op == OP_CMP)) ? ~r_m : r_m;
    w_cin   = (r_op == OP_CMP) ? 1'b1 : r_flags[0];
    w_sum9  = {1'b0, r_a} + {1'b0, w_m_eff} + {8'h00, w_cin};
    w_v     = ~(r_a[7] ^ w_m_eff[7]) & (r_a[7] ^ w_sum9[7]);
    w_hc    = w_sum9[4] ^ r_a[4] ^ w_m_eff[4];
    w_res   = 8'h00;
    w_wr_a  = 1'b0;
    w_flags = r_flags;
    case (r_op)
      OP_ORA: begin w_res = r_a | r_m; w_wr_a = 1'b1; end
      OP_AND: begin w_res = r_a & r_m; w_wr_a = 1'b1; end
      OP_EOR: begin w_res = r_a ^ r_m; w_wr_a = 1'b1; end
      OP_LDA: begin w_res = r_m;       w_wr_a = 1'b1; end
      OP_ADC, OP_SBC: begin
        w_res  = w_sum9[7:0];
        w_wr_a = 1'b1;
      end
      OP_CMP: w_res = w_sum9[7:0];
      default: w_res = 8'h00;
    endcase
    case (r_op)
      OP_ORA, OP_AND, OP_EOR, OP_LDA:
        w_flags = {w_res[7], r_flags[2], (w_res == 8'h00), r_flags[0]};
      OP_ADC, OP_SBC:
        w_flags = {w_res[7], w_v, (w_res == 8'h00), w_sum9[8]};
      OP_CMP:
        w_flags = {w_res[7], r_flags[2], (w_res == 8'h00), w_sum9[8]};
      default: w_flags = r_flags;
    endcase
  end

  // BCD correction on the latched binary result
  always_comb begin
    w_lo_fix = 1'b0;
    w_hi_fix = 1'b0;
    w_adj1   = {1'b0, r_sum9[7:0]};
    w_dadj   = r_sum9[7:0];
    w_dc     = r_sum9[8];
    if (r_op == OP_ADC) begin
      w_lo_fix = (r_sum9[3:0] > 4'd9) || r_hc;
      w_adj1   = {1'b0, r_sum9[7:0]} + (w_lo_fix ? 9'h006 : 9'h000);
      w_hi_fix = (w_adj1[7:4] > 4'd9) || r_sum9[8] || w_adj1[8];
      w_dadj   = w_adj1[7:0] + (w_hi_fix ? 8'h60 : 8'h00);
      w_dc     = w_hi_fix;
    end else begin
      w_dadj = r_sum9[7:0] - (r_hc ? 8'h00 : 8'h06) - (r_sum9[8] ? 8'h00 : 8'h60);
      w_dc   = r_sum9[8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op      <= 3'b000;
      r_m       <= 8'h00;
      r_ea      <= 16'h0000;
      r_d       <= 1'b0;
      r_a       <= A_INIT;
      r_flags   <= 4'b0000;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 16'h0000;
      r_wr_data <= 8'h00;
      r_sum9    <= 9'h000;
      r_hc      <= 1'b0;
      r_v       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_op_valid) begin
            r_op <= i_opcode;
            r_m  <= i_operand;
            r_ea <= i_ea;
            r_d  <= i_d;
          end
        end
        S_EXEC: begin
          if (r_op == OP_STA) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ea;
            r_wr_data <= r_a;
          end else if (w_dec) begin
            r_sum9 <= w_sum9;
            r_hc   <= w_hc;
            r_v    <= w_v;
          end else begin
            if (w_wr_a) r_a <= w_res;
            r_flags <= w_flags;
            r_done  <= 1'b1;
          end
        end
        S_DEC_ADJ: begin
          r_a     <= w_dadj;
          r_flags <= {w_dadj[7], r_v, (w_dadj == 8'h00), w_dc};
          r_done  <= 1'b1;
        end
        S_STORE: r_done <= 1'b1;
        default: r_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed-vector bench for exec_unit with hand-computed A/flag results and latencies.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  opcode;
  logic [7:0]  operand;
  logic [15:0] ea;
  logic        d;
  logic        busy, done, wr_en;
  logic [7:0]  reg_a, wr_data;
  logic [3:0]  flags;
  logic [15:0] wr_addr;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt;
  logic [15:0] wr_addr_seen;
  logic [7:0]  wr_data_seen;

  localparam logic [2:0] ORA = 3'b000, AND_ = 3'b001, EOR = 3'b010, ADC = 3'b011;
  localparam logic [2:0] STA = 3'b100, LDA = 3'b101, CMP = 3'b110, SBC = 3'b111;

  exec_unit #(.A_INIT(8'h00), .DECIMAL_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_op_valid(op_valid), .i_opcode(opcode),
    .i_operand(operand), .i_ea(ea), .i_d(d),
    .o_busy(busy), .o_done(done), .o_reg_a(reg_a), .o_flags(flags),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE; lat counts the accept edge as cycle 1
  task automatic run_op(input logic [2:0] op, input logic [7:0] m, input logic [15:0] addr,
                        input logic dec, output int lat);
    int n;
    op_valid = 1'b1; opcode = op; operand = m; ea = addr; d = dec;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    n = 1; wr_cnt = 0;
    while (!done && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (wr_en) begin wr_cnt++; wr_addr_seen = wr_addr; wr_data_seen = wr_data; end
    end
    lat = done ? n : -1;
    chk("done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic op_chk(input string tag, input logic [2:0] op, input logic [7:0] m, input logic dec,
                        input logic [7:0] exp_a, input logic [3:0] exp_f);
    int lat;
    run_op(op, m, 16'h0000, dec, lat);
    chk({tag, "_a"}, {24'd0, reg_a}, {24'd0, exp_a});
    chk({tag, "_nvzc"}, {28'd0, flags}, {28'd0, exp_f});
  endtask

  initial begin
    int lat, dn;
    rst = 1'b1; op_valid = 1'b0; opcode = 3'b000; operand = 8'h00; ea = 16'h0000; d = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_a", {24'd0, reg_a}, 32'h00);
    chk("rst_flags", {28'd0, flags}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr}, 32'h0000);
    rst = 1'b0;
    @(negedge clk);

    run_op(LDA, 8'h80, 16'h0000, 1'b0, lat);
    chk("lda_lat", lat, 2);
    chk("lda_a", {24'd0, reg_a}, 32'h80);
    chk("lda_nvzc", {28'd0, flags}, 32'h8);

    op_chk("lda50", LDA, 8'h50, 1'b0, 8'h50, 4'b0000);
    run_op(ADC, 8'h50, 16'h0000, 1'b0, lat);
    chk("adc_bin_lat", lat, 2);
    chk("adc_ovf_a", {24'd0, reg_a}, 32'hA0);
    chk("adc_ovf_nvzc", {28'd0, flags}, 32'hC);
    op_chk("adc_carry", ADC, 8'h60, 1'b0, 8'h00, 4'b0011);

    op_chk("lda19", LDA, 8'h19, 1'b0, 8'h19, 4'b0001);
    op_chk("cmp_clr_c", CMP, 8'hFF, 1'b0, 8'h19, 4'b0000);
    run_op(ADC, 8'h28, 16'h0000, 1'b1, lat);
    chk("adc_dec_lat", lat, 3);
    chk("adc_dec_a", {24'd0, reg_a}, 32'h47);
    chk("adc_dec_nvzc", {28'd0, flags}, 32'h0);
    op_chk("lda99", LDA, 8'h99, 1'b0, 8'h99, 4'b1000);
    op_chk("adc_dec_wrap", ADC, 8'h01, 1'b1, 8'h00, 4'b0011);
    op_chk("lda50b", LDA, 8'h50, 1'b0, 8'h50, 4'b0001);
    op_chk("sbc_dec", SBC, 8'h01, 1'b1, 8'h49, 4'b0001);
    op_chk("sbc_bin", SBC, 8'h49, 1'b0, 8'h00, 4'b0011);

    op_chk("ldaf0", LDA, 8'hF0, 1'b0, 8'hF0, 4'b1001);
    op_chk("ora", ORA, 8'h0F, 1'b0, 8'hFF, 4'b1001);
    op_chk("and", AND_, 8'h3C, 1'b0, 8'h3C, 4'b0001);
    op_chk("eor", EOR, 8'h3C, 1'b0, 8'h00, 4'b0011);

    op_chk("lda3c", LDA, 8'h3C, 1'b0, 8'h3C, 4'b0001);
    run_op(STA, 8'h00, 16'h0200, 1'b0, lat);
    chk("sta_wr_cycles", wr_cnt, 1);
    chk("sta_wr_addr", {16'd0, wr_addr_seen}, 32'h0200);
    chk("sta_wr_data", {24'd0, wr_data_seen}, 32'h3C);
    chk("sta_a", {24'd0, reg_a}, 32'h3C);
    chk("sta_nvzc", {28'd0, flags}, 32'h1);

    op_chk("lda10", LDA, 8'h10, 1'b0, 8'h10, 4'b0001);
    op_chk("cmp_lt", CMP, 8'h20, 1'b0, 8'h10, 4'b1000);

    // OP_VALID held high through the whole operation must yield a single DONE
    op_valid = 1'b1; opcode = LDA; operand = 8'h77; d = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin dn++; op_valid = 1'b0; end
    end
    op_valid = 1'b0;
    chk("held_valid_dones", dn, 1);
    chk("held_valid_a", {24'd0, reg_a}, 32'h77);

    // Reset while in EXEC aborts the op
    op_valid = 1'b1; opcode = LDA; operand = 8'h55;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dn++;
      @(posedge clk); @(negedge clk);
    end
    chk("rst_exec_dones", dn, 0);
    chk("rst_exec_a", {24'd0, reg_a}, 32'h00);
    chk("rst_exec_flags", {28'd0, flags}, 32'h0);
    chk("rst_exec_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
